// File: rtl/arb_rr_4_32_pkg.sv
// Shared definitions for the 4-channel round-robin bus arbiter and its 32-bit mux.
package arb_rr_4_32_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int DATA_W = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // One-hot decode of a channel index, used to build the grant vector.
    function automatic logic [NUM_CH-1:0] sel_decode(input logic [SEL_W-1:0] sel);
        logic [NUM_CH-1:0] dec;
        dec      = {NUM_CH{1'b0}};
        dec[sel] = 1'b1;
        return dec;
    endfunction

endpackage

// File: rtl/arb_rr_4_32_if.sv
// Request/grant bundle between requesters, the arbiter and the downstream mux.
// With ARB_LOCK_EN defined the bundle carries the per-channel lock vector.
interface arb_rr_4_32_if;
    import arb_rr_4_32_pkg::*;

    logic [NUM_CH-1:0] req;
    logic              sink_ready;
    logic [SEL_W-1:0]  select;
    logic              enable;
    logic [NUM_CH-1:0] grant;
    logic              xfer;
`ifdef ARB_LOCK_EN
    logic [NUM_CH-1:0] lock;

    modport slave  (input  req, sink_ready, lock, output select, enable, grant, xfer);
    modport master (output req, sink_ready, lock, input  select, enable, grant, xfer);
`else
    modport slave  (input  req, sink_ready, output select, enable, grant, xfer);
    modport master (output req, sink_ready, input  select, enable, grant, xfer);
`endif

endinterface

// File: rtl/arb_rr_4_32_rr_pick_4.sv
// Combinational round-robin picker: first requester after 'last', optionally
// ignoring the current owner (which is always the channel held in 'last').
module rr_pick_4
    import arb_rr_4_32_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  last,
    input  logic              excl_owner,
    output logic [SEL_W-1:0]  pick,
    output logic              any_req
);

    logic [NUM_CH-1:0] req_m_s;

    // Mask the owner when searching for a competitor.
    always_comb begin
        req_m_s = req;
        if (excl_owner) begin
            req_m_s[last] = 1'b0;
        end else begin
            req_m_s = req;
        end
    end

    // Scan last+1, last+2, last+3, last and keep the first hit.
    always_comb begin
        logic [SEL_W-1:0] idx_v;
        logic             found_v;
        pick    = {SEL_W{1'b0}};
        found_v = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx_v = last + SEL_W'(i);
            if (!found_v && req_m_s[idx_v]) begin
                pick    = idx_v;
                found_v = 1'b1;
            end else begin
                found_v = found_v;
            end
        end
        any_req = found_v;
    end

endmodule

// File: rtl/arb_rr_4_32.sv
// Round-robin arbiter driving select/enable of the 4-to-1 32-bit bus mux, with a
// per-tenure hold limit. Optional macro ARB_LOCK_EN lets the owner lock the bus.
module arb_rr_4_32
    import arb_rr_4_32_pkg::*;
#(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 8
) (
    input  logic          clock,
    input  logic          reset,
    arb_rr_4_32_if.slave  bus
);

    state_t            state_r, state_n;
    logic [SEL_W-1:0]  sel_r, sel_n;
    logic              en_r, en_n;
    logic [NUM_CH-1:0] grant_r, grant_n;
    logic [CNT_W-1:0]  hold_cnt_r, hold_cnt_n;
    logic [SEL_W-1:0]  last_r, last_n;

    logic              xfer_s;
    logic              excl_s;
    logic [SEL_W-1:0]  pick_s;
    logic              any_s;
    logic              lock_hold_s;
    logic              limit_s;
    logic              rel_a_s;
    logic              rel_b_s;

    assign xfer_s = en_r & bus.sink_ready;
    assign excl_s = (state_r == ST_GRANT);

`ifdef ARB_LOCK_EN
    assign lock_hold_s = bus.lock[sel_r];
`else
    assign lock_hold_s = 1'b0;
`endif

    rr_pick_4 u_pick (
        .req        (bus.req),
        .last       (last_r),
        .excl_owner (excl_s),
        .pick       (pick_s),
        .any_req    (any_s)
    );

    // While granted, any_s means a channel other than the owner is requesting.
    assign limit_s = xfer_s && (hold_cnt_r == CNT_W'(HOLD_MAX - 1));
    assign rel_a_s = ~bus.req[sel_r];
    assign rel_b_s = limit_s & any_s & ~lock_hold_s;

    // Next-state and next-output decision.
    always_comb begin
        state_n    = state_r;
        sel_n      = sel_r;
        en_n       = en_r;
        hold_cnt_n = hold_cnt_r;
        last_n     = last_r;
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    state_n    = ST_GRANT;
                    sel_n      = pick_s;
                    en_n       = 1'b1;
                    hold_cnt_n = {CNT_W{1'b0}};
                    last_n     = pick_s;
                end else begin
                    en_n       = 1'b0;
                end
            end
            ST_GRANT: begin
                if (rel_a_s || rel_b_s) begin
                    hold_cnt_n = {CNT_W{1'b0}};
                    if (any_s) begin
                        sel_n  = pick_s;
                        last_n = pick_s;
                        en_n   = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                        en_n    = 1'b0;
                    end
                end else if (xfer_s) begin
                    // Limit reached without a winning competitor: start a fresh tenure count.
                    if (limit_s) begin
                        hold_cnt_n = {CNT_W{1'b0}};
                    end else begin
                        hold_cnt_n = hold_cnt_r + CNT_W'(1);
                    end
                end else begin
                    hold_cnt_n = hold_cnt_r;
                end
            end
            default: begin
                state_n    = ST_IDLE;
                en_n       = 1'b0;
                hold_cnt_n = {CNT_W{1'b0}};
            end
        endcase
    end

    // Grant is derived from the next select/enable so it is registered alongside them.
    always_comb begin
        if (en_n) begin
            grant_n = sel_decode(sel_n);
        end else begin
            grant_n = {NUM_CH{1'b0}};
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            sel_r      <= {SEL_W{1'b0}};
            en_r       <= 1'b0;
            grant_r    <= {NUM_CH{1'b0}};
            hold_cnt_r <= {CNT_W{1'b0}};
            last_r     <= {SEL_W{1'b1}};
        end else begin
            state_r    <= state_n;
            sel_r      <= sel_n;
            en_r       <= en_n;
            grant_r    <= grant_n;
            hold_cnt_r <= hold_cnt_n;
            last_r     <= last_n;
        end
    end

    assign bus.select = sel_r;
    assign bus.enable = en_r;
    assign bus.grant  = grant_r;
    assign bus.xfer   = xfer_s;

endmodule

// File: tb/tb_arb_rr_4_32.sv
// Directed bench for arb_rr_4_32: a HOLD_MAX=4 instance and a HOLD_MAX=1 instance.
module tb_arb_rr_4_32;

    logic clock;
    logic reset;
    int   n_assert;
    int   n_fail;

    arb_rr_4_32_if bus_a ();
    arb_rr_4_32_if bus_b ();

    arb_rr_4_32 #(.HOLD_MAX(4), .CNT_W(8)) u_dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    arb_rr_4_32 #(.HOLD_MAX(1), .CNT_W(8)) u_dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic check_a(input string tag, input logic [1:0] sel, input logic en,
                           input logic [3:0] gnt);
        check_eq({tag, ".select"}, 32'(bus_a.select), 32'(sel));
        check_eq({tag, ".enable"}, 32'(bus_a.enable), 32'(en));
        check_eq({tag, ".grant"},  32'(bus_a.grant),  32'(gnt));
    endtask

    initial begin
        logic [1:0] exp_sel;
        logic [3:0] one_hot;
        n_assert = 0;
        n_fail   = 0;
        bus_a.req = 4'b0000;  bus_a.sink_ready = 1'b0;
        bus_b.req = 4'b0000;  bus_b.sink_ready = 1'b0;
`ifdef ARB_LOCK_EN
        bus_a.lock = 4'b0000;
        bus_b.lock = 4'b0000;
`endif
        reset = 1'b1;
        repeat (3) tick();
        check_a("reset", 2'd0, 1'b0, 4'b0000);
        reset = 1'b0;

        // Idle with no requests
        bus_a.sink_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_a("idle", 2'd0, 1'b0, 4'b0000);
            check_eq("idle.xfer", 32'(bus_a.xfer), 32'd0);
        end

        // req=1010: channel 1 first, alternate every 4 transfers without idle cycles
        bus_a.req = 4'b1010;
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_sel = (k >= 5 && k <= 8) ? 2'd3 : 2'd1;
            one_hot = 4'b0001 << exp_sel;
            check_a($sformatf("rot1010_%0d", k), exp_sel, 1'b1, one_hot);
        end
        bus_a.req = 4'b0000;
        tick();
        check_a("drop_all", 2'd1, 1'b0, 4'b0000);
        check_eq("drop_all.xfer", 32'(bus_a.xfer), 32'd0);

        // Owner 2 stalled by backpressure: hold count must freeze
        bus_a.req = 4'b0100;
        tick();
        check_a("own2", 2'd2, 1'b1, 4'b0100);
        bus_a.req = 4'b0101;
        tick();
        tick();
        check_a("own2_x2", 2'd2, 1'b1, 4'b0100);
        bus_a.sink_ready = 1'b0;
        #1;
        check_eq("stall.xfer", 32'(bus_a.xfer), 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check_eq("stall.select", 32'(bus_a.select), 32'd2);
        end
        bus_a.sink_ready = 1'b1;
        #1;
        check_eq("resume.xfer", 32'(bus_a.xfer), 32'd1);
        tick();
        check_a("resume_3rd", 2'd2, 1'b1, 4'b0100);
        tick();
        check_a("resume_limit", 2'd0, 1'b1, 4'b0001);

        // Owner 0 drops request mid-tenure while channel 3 waits
        bus_a.req = 4'b1001;
        tick();
        check_a("own0", 2'd0, 1'b1, 4'b0001);
        bus_a.req = 4'b1000;
        tick();
        check_a("drop_to3", 2'd3, 1'b1, 4'b1000);
        bus_a.req = 4'b0000;
        tick();
        check_a("drop_to_idle", 2'd3, 1'b0, 4'b0000);

        // Reset while granted, then a fresh single-cycle grant
        bus_a.req = 4'b0010;
        tick();
        check_a("pre_reset", 2'd1, 1'b1, 4'b0010);
        reset = 1'b1;
        tick();
        check_a("mid_reset", 2'd0, 1'b0, 4'b0000);
        reset = 1'b0;
        bus_a.req = 4'b0001;
        tick();
        check_a("post_reset", 2'd0, 1'b1, 4'b0001);
        bus_a.req = 4'b0000;
        tick();

        // HOLD_MAX=1 with all four requesting: strict rotation
        check_eq("b_idle.enable", 32'(bus_b.enable), 32'd0);
        bus_b.req = 4'b1111;
        bus_b.sink_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            exp_sel = 2'(k % 4);
            one_hot = 4'b0001 << exp_sel;
            check_eq($sformatf("b_rot%0d.select", k), 32'(bus_b.select), 32'(exp_sel));
            check_eq($sformatf("b_rot%0d.enable", k), 32'(bus_b.enable), 32'd1);
            check_eq($sformatf("b_rot%0d.grant", k),  32'(bus_b.grant),  32'(one_hot));
        end
        bus_b.req = 4'b0000;

`ifdef ARB_LOCK_EN
        // Locked owner keeps the bus past HOLD_MAX despite a competitor
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus_a.req  = 4'b0011;
        bus_a.lock = 4'b0001;
        tick();
        check_a("lock_grant", 2'd0, 1'b1, 4'b0001);
        for (int k = 0; k < 8; k++) begin
            tick();
            check_eq("lock_hold.select", 32'(bus_a.select), 32'd0);
        end
        bus_a.req  = 4'b0000;
        bus_a.lock = 4'b0000;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
